// File: rtl/crc_frame_encoder_if.sv
// Beat-level handshake bundle for crc_frame_encoder.
// The master side supplies input beats and the downstream stall.
// The slave side (the encoder) returns readiness, output beats and the overflow pulse.
interface crc_frame_encoder_if #(
    parameter int DATA_W = 8
);
    logic              startin;
    logic              pushin;
    logic              endin;
    logic [DATA_W-1:0] datain;
    logic              readyout;
    logic              stopin;
    logic              pushout;
    logic              startout;
    logic              endout;
    logic [DATA_W-1:0] dataout;
    logic              errout;

    modport master (
        output startin, pushin, endin, datain, stopin,
        input  readyout, pushout, startout, endout, dataout, errout
    );

    modport slave (
        input  startin, pushin, endin, datain, stopin,
        output readyout, pushout, startout, endout, dataout, errout
    );
endinterface

// File: rtl/crc_frame_encoder.sv
// crc_frame_encoder: collects one frame of beats, computes an MSB-first CRC
// on the fly, then replays the payload followed by the CRC beats under
// downstream back-pressure.
// Optional feature: define CRC_ENC_FRAMECNT_EN to add the frames_out /
// drops_out statistics counters.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a beat with startin; readyout high
// ST_COLLECT   | storing payload beats and updating the CRC; readyout high
// ST_SEND_DATA | replaying buffered payload beats; readyout low
// ST_SEND_CRC  | emitting (crc ^ XOROUT) most-significant beat first
module crc_frame_encoder #(
    parameter int               DATA_W = 8,
    parameter int               DEPTH  = 16,
    parameter int               CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = 32'h04C11DB7,
    parameter logic [CRC_W-1:0] INIT   = 32'hFFFFFFFF,
    parameter logic [CRC_W-1:0] XOROUT = 32'h00000000
) (
    input  logic                     clk,
    input  logic                     reset,
`ifdef CRC_ENC_FRAMECNT_EN
    output logic [15:0]              frames_out,
    output logic [15:0]              drops_out,
`endif
    crc_frame_encoder_if.slave       bus
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CNT_W     = AW + 1;
    localparam int CRC_BEATS = CRC_W / DATA_W;
    localparam int CB_W      = $clog2(CRC_BEATS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND_DATA,
        ST_SEND_CRC
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic [CB_W-1:0]   crc_beat_q, crc_beat_d;
    logic [CRC_W-1:0]  tx_sh_q, tx_sh_d;
    logic              ready_q, ready_d;
    logic              push_q, push_d;
    logic              start_q, start_d;
    logic              end_q, end_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              accept;
    logic              consume;
    logic              last_payload;
    logic [CRC_W-1:0]  crc_fin;

    // One DATA_W-bit step of the non-reflected CRC, MSB of the beat first.
    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0]  crc_in,
        input logic [DATA_W-1:0] data
    );
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    assign accept       = bus.pushin && ready_q;
    assign consume      = push_q && !bus.stopin;
    assign last_payload = (CNT_W'(rd_idx_q) == count_q - CNT_W'(1));
    assign crc_fin      = crc_q ^ XOROUT;

    // Next-state and next-output logic; every output is registered, so the
    // beat that goes out next cycle is chosen here.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        crc_d      = crc_q;
        rd_idx_d   = rd_idx_q;
        crc_beat_d = crc_beat_q;
        tx_sh_d    = tx_sh_q;
        push_d     = push_q;
        start_d    = start_q;
        end_d      = end_q;
        data_d     = data_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = count_q[AW-1:0];
        wr_data    = bus.datain;

        unique case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept && bus.startin) begin
                    // A start beat always (re)opens a frame, also mid-collect.
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    crc_d   = crc_step(INIT, bus.datain);
                    count_d = CNT_W'(1);
                    if (bus.endin) begin
                        // Single-beat frame: buffer is written this same edge,
                        // so the first output beat comes straight from datain.
                        state_d  = ST_SEND_DATA;
                        push_d   = 1'b1;
                        start_d  = 1'b1;
                        end_d    = 1'b0;
                        data_d   = bus.datain;
                        rd_idx_d = '0;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else if (accept && state_q == ST_COLLECT) begin
                    if (count_q == CNT_W'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                        count_d = '0;
                        crc_d   = INIT;
                    end else begin
                        wr_en   = 1'b1;
                        crc_d   = crc_step(crc_q, bus.datain);
                        count_d = count_q + CNT_W'(1);
                        if (bus.endin) begin
                            state_d  = ST_SEND_DATA;
                            push_d   = 1'b1;
                            start_d  = 1'b1;
                            end_d    = 1'b0;
                            data_d   = mem[0];
                            rd_idx_d = '0;
                        end
                    end
                end
            end

            ST_SEND_DATA: begin
                if (consume) begin
                    start_d = 1'b0;
                    if (last_payload) begin
                        state_d    = ST_SEND_CRC;
                        data_d     = crc_fin[CRC_W-1 -: DATA_W];
                        tx_sh_d    = crc_fin << DATA_W;
                        crc_beat_d = '0;
                        end_d      = (CRC_BEATS == 1);
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                        data_d   = mem[rd_idx_q + AW'(1)];
                    end
                end
            end

            ST_SEND_CRC: begin
                if (consume) begin
                    if (crc_beat_q == CB_W'(CRC_BEATS - 1)) begin
                        state_d = ST_IDLE;
                        push_d  = 1'b0;
                        end_d   = 1'b0;
                        data_d  = '0;
                        count_d = '0;
                        crc_d   = INIT;
                    end else begin
                        crc_beat_d = crc_beat_q + CB_W'(1);
                        data_d     = tx_sh_q[CRC_W-1 -: DATA_W];
                        tx_sh_d    = tx_sh_q << DATA_W;
                        end_d      = (crc_beat_q + CB_W'(1) == CB_W'(CRC_BEATS - 1));
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            crc_q      <= INIT;
            rd_idx_q   <= '0;
            crc_beat_q <= '0;
            tx_sh_q    <= '0;
            ready_q    <= 1'b0;
            push_q     <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            crc_q      <= crc_d;
            rd_idx_q   <= rd_idx_d;
            crc_beat_q <= crc_beat_d;
            tx_sh_q    <= tx_sh_d;
            ready_q    <= ready_d;
            push_q     <= push_d;
            start_q    <= start_d;
            end_q      <= end_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Payload buffer; contents are don't-care outside a frame, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef CRC_ENC_FRAMECNT_EN
    // Statistics: completed frames and overflow drops, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_out <= '0;
            drops_out  <= '0;
        end else begin
            if (consume && end_q) begin
                frames_out <= frames_out + 16'd1;
            end
            if (err_q) begin
                drops_out <= drops_out + 16'd1;
            end
        end
    end
`endif

    assign bus.readyout = ready_q;
    assign bus.pushout  = push_q;
    assign bus.startout = start_q;
    assign bus.endout   = end_q;
    assign bus.dataout  = data_q;
    assign bus.errout   = err_q;

endmodule

// File: tb/tb_crc_frame_encoder.sv
// Self-checking bench for crc_frame_encoder (default parameters).
// Expected CRCs come from polynomial long division of the augmented message.
module tb_crc_frame_encoder;

    localparam logic [31:0] POLY   = 32'h04C11DB7;
    localparam logic [31:0] INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] XOROUT = 32'h00000000;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   stall_mode = 0;
    int   cyc = 0;

    crc_frame_encoder_if #(.DATA_W(8)) bus ();

`ifdef CRC_ENC_FRAMECNT_EN
    logic [15:0] frames_out;
    logic [15:0] drops_out;
`endif

    crc_frame_encoder dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CRC_ENC_FRAMECNT_EN
        .frames_out (frames_out),
        .drops_out  (drops_out),
`endif
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Frame stimulus table.
    logic [7:0] fb [32];
    bit         fs [32];
    bit         fe [32];

    // Captured consumed output beats and event bookkeeping.
    logic [7:0] cap_data  [$];
    bit         cap_start [$];
    bit         cap_end   [$];
    int         cap_cyc   [$];
    logic [7:0] exp_q     [$];
    int  err_cnt = 0, err_cyc = 0, acc_cyc = 0, end_acc_cyc = 0;
    int  push_samples = 0, hold_viol = 0, ready_viol = 0;
    bit  end_seen = 0;
    bit  prev_stall = 0;
    logic [7:0] prev_data;
    logic prev_start, prev_end;

    // Observe the bus mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (bus.pushout !== 1'b1 || bus.dataout !== prev_data ||
                               bus.startout !== prev_start || bus.endout !== prev_end))
                hold_viol++;
            if (bus.pushout) push_samples++;
            if (bus.pushout && bus.readyout) ready_viol++;
            if (bus.errout) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (bus.pushin && bus.readyout) begin
                acc_cyc = cyc;
                if (bus.endin) end_acc_cyc = cyc;
            end
            if (bus.pushout && !bus.stopin) begin
                cap_data.push_back(bus.dataout);
                cap_start.push_back(bus.startout);
                cap_end.push_back(bus.endout);
                cap_cyc.push_back(cyc);
                if (bus.endout) end_seen = 1'b1;
            end
            prev_stall = bus.pushout && bus.stopin;
            prev_data  = bus.dataout;
            prev_start = bus.startout;
            prev_end   = bus.endout;
        end
    end

    // Downstream stall generator.
    initial begin
        bus.stopin = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (stall_mode)
                1:       bus.stopin = ~bus.stopin;
                2:       bus.stopin = 1'($urandom_range(0, 1));
                default: bus.stopin = 1'b0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as the remainder of (INIT*x^(8n) + M*x^32) mod G, by long division.
    function automatic logic [31:0] model_crc(input int first, input int n);
        bit d [0:299];
        logic [31:0] r;
        for (int i = 0; i < 300; i++) d[i] = 1'b0;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 8; b++) d[8*k+b] = fb[first+k][7-b];
        for (int i = 0; i < 32; i++) d[i] = d[i] ^ INIT[31-i];
        for (int i = 0; i < 8*n; i++) begin
            if (d[i]) begin
                d[i] = 1'b0;
                for (int j = 0; j < 32; j++) d[i+1+j] = d[i+1+j] ^ POLY[31-j];
            end
        end
        r = '0;
        for (int j = 0; j < 32; j++) r[31-j] = d[8*n+j];
        return r ^ XOROUT;
    endfunction

    task automatic build_expected(input int first, input int n);
        logic [31:0] c;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(fb[first+k]);
        c = model_crc(first, n);
        exp_q.push_back(c[31:24]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 32; i++) begin
            fb[i] = 8'h00;
            fs[i] = 1'b0;
            fe[i] = 1'b0;
        end
    endtask

    task automatic clear_capture();
        cap_data.delete();
        cap_start.delete();
        cap_end.delete();
        cap_cyc.delete();
        end_seen = 1'b0;
    endtask

    task automatic load_check_frame(input int offset);
        for (int i = 0; i < 9; i++) fb[offset+i] = 8'h31 + 8'(i);
        fs[offset] = 1'b1;
        fe[offset+8] = 1'b1;
    endtask

    task automatic load_check_expected();
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h76);
        exp_q.push_back(8'hE6);
        exp_q.push_back(8'hE7);
    endtask

    // Called at posedge+1; leaves the bus idle at posedge+1.
    task automatic drive_frame(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (bus.readyout !== 1'b1 && w < 200) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (w >= 200) chk("ready_timeout", 32'(bus.readyout), 32'd1);
            bus.pushin  = 1'b1;
            bus.startin = fs[i];
            bus.endin   = fe[i];
            bus.datain  = fb[i];
            @(posedge clk);
            #1;
        end
        bus.pushin  = 1'b0;
        bus.startin = 1'b0;
        bus.endin   = 1'b0;
    endtask

    // Returns at negedge+1 of the cycle in which the endout beat is consumed.
    task automatic wait_done(input string tag);
        int w;
        w = 0;
        while (!end_seen && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk({tag, "_done"}, 32'(end_seen), 32'd1);
    endtask

    task automatic compare_frame(input string tag);
        int n;
        chk({tag, "_len"}, cap_data.size(), exp_q.size());
        n = (cap_data.size() < exp_q.size()) ? cap_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(exp_q[i]));
            chk($sformatf("%s_sop%0d", tag, i), 32'(cap_start[i]), 32'(i == 0));
            chk($sformatf("%s_eop%0d", tag, i), 32'(cap_end[i]), 32'(i == exp_q.size() - 1));
        end
    endtask

    // Cycle after the last CRC beat is consumed: ready again, nothing pushed.
    task automatic check_post(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_post_ready"}, 32'(bus.readyout), 32'd1);
        chk({tag, "_post_push"}, 32'(bus.pushout), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e0, h0, r0, p0, n, w;
        reset       = 1'b0;
        bus.pushin  = 1'b0;
        bus.startin = 1'b0;
        bus.endin   = 1'b0;
        bus.datain  = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.readyout), 32'd0);
        chk("rst_push", 32'(bus.pushout), 32'd0);
        chk("rst_sop", 32'(bus.startout), 32'd0);
        chk("rst_eop", 32'(bus.endout), 32'd0);
        chk("rst_data", 32'(bus.dataout), 32'd0);
        chk("rst_err", 32'(bus.errout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("ready_after_reset", 32'(bus.readyout), 32'd1);
        @(posedge clk);
        #1;

        // Check value, no stall.
        clear_frame();
        load_check_frame(0);
        load_check_expected();
        clear_capture();
        e0 = err_cnt;
        drive_frame(9);
        wait_done("check");
        compare_frame("check");
        if (cap_cyc.size() > 0) begin
            chk("check_first_lat", 32'(cap_cyc[0] - end_acc_cyc), 32'd1);
            chk("check_span", 32'(cap_cyc[cap_cyc.size()-1] - cap_cyc[0]), 32'd12);
        end
        chk("check_err", 32'(err_cnt - e0), 32'd0);
        check_post("check");

        // Back-pressure: stopin toggling every cycle.
        stall_mode = 1;
        clear_capture();
        h0 = hold_viol;
        r0 = ready_viol;
        drive_frame(9);
        wait_done("bp");
        compare_frame("bp");
        chk("bp_hold", 32'(hold_viol - h0), 32'd0);
        chk("bp_ready_low", 32'(ready_viol - r0), 32'd0);
        stall_mode = 0;
        check_post("bp");

        // Overflow: 17 beats, no endin.
        clear_frame();
        for (int i = 0; i < 17; i++) fb[i] = 8'($urandom);
        fs[0] = 1'b1;
        clear_capture();
        e0 = err_cnt;
        p0 = push_samples;
        drive_frame(17);
        repeat (5) @(negedge clk);
        #1;
        chk("ovf_err_count", 32'(err_cnt - e0), 32'd1);
        chk("ovf_err_lat", 32'(err_cyc - acc_cyc), 32'd1);
        chk("ovf_no_push", 32'(push_samples - p0), 32'd0);
        chk("ovf_ready", 32'(bus.readyout), 32'd1);
        @(posedge clk);
        #1;

        // Abort: AA, BB, then a restart on 0x31.
        clear_frame();
        fb[0] = 8'hAA;
        fb[1] = 8'hBB;
        fs[0] = 1'b1;
        load_check_frame(2);
        load_check_expected();
        clear_capture();
        e0 = err_cnt;
        drive_frame(11);
        wait_done("abort");
        compare_frame("abort");
        chk("abort_err", 32'(err_cnt - e0), 32'd0);
        check_post("abort");

        // Single-beat frame.
        clear_frame();
        fb[0] = 8'h00;
        fs[0] = 1'b1;
        fe[0] = 1'b1;
        build_expected(0, 1);
        clear_capture();
        drive_frame(1);
        wait_done("single");
        compare_frame("single");
        check_post("single");

        // Same frame again, reset asserted mid CRC emission.
        clear_capture();
        drive_frame(1);
        w = 0;
        while (cap_data.size() < 3 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("rst_mid_reached", 32'(cap_data.size() >= 3), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_push", 32'(bus.pushout), 32'd0);
        chk("rst_mid_ready", 32'(bus.readyout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        p0 = push_samples;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_rel_ready", 32'(bus.readyout), 32'd1);
        chk("rst_rel_no_push", 32'(push_samples - p0), 32'd0);
        @(posedge clk);
        #1;

        // Random frames with random stalls.
        h0 = hold_viol;
        r0 = ready_viol;
        for (int f = 0; f < 6; f++) begin
            clear_frame();
            n = int'($urandom_range(1, 16));
            for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
            fs[0] = 1'b1;
            fe[n-1] = 1'b1;
            build_expected(0, n);
            clear_capture();
            stall_mode = 2;
            drive_frame(n);
            wait_done($sformatf("rnd%0d", f));
            compare_frame($sformatf("rnd%0d", f));
            stall_mode = 0;
            repeat (2) @(posedge clk);
            #1;
        end
        chk("rnd_hold", 32'(hold_viol - h0), 32'd0);
        chk("rnd_ready_low", 32'(ready_viol - r0), 32'd0);

`ifdef CRC_ENC_FRAMECNT_EN
        // Statistics counters from a fresh reset.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("cnt_rst_frames", 32'(frames_out), 32'd0);
        chk("cnt_rst_drops", 32'(drops_out), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            clear_frame();
            load_check_frame(0);
            clear_capture();
            drive_frame(9);
            wait_done($sformatf("cnt_good%0d", g));
            @(posedge clk);
            #1;
        end
        clear_frame();
        fs[0] = 1'b1;
        drive_frame(17);
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_frames", 32'(frames_out), 32'd2);
        chk("cnt_drops", 32'(drops_out), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_frame_encoder.md
# crc_frame_encoder

Parametrised frame encoder for the CRC datapath. Accepts one frame of DATA_W-bit beats on a start/push/end input handshake and computes the CRC on the fly. It buffers up to DEPTH beats and re-emits the frame with the CRC appended as trailing beats, under downstream back-pressure. It supersedes the fixed 4-byte capture stage and adds frame delimiting, overflow detection, CRC generation and output sequencing.

## Interface
- DATA_W, 8, beat width in bits
- DEPTH, 16, maximum payload beats per frame (power of 2, ≥2)
- CRC_W, 32, CRC width; must be a multiple of DATA_W
- POLY, 32'h04C11DB7, generator polynomial (normal form, implicit top bit)
- INIT, 32'hFFFFFFFF, CRC register value at frame start
- XOROUT, 32'h00000000, value XORed into the final CRC
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- startin  in  1  marks the first beat of a frame; qualified by pushin
- pushin  in  1  input beat valid
- endin  in  1  marks the last beat of a frame; qualified by pushin
- datain  in  DATA_W  input beat
- readyout  out  1  block can accept a beat this cycle
- stopin  in  1  downstream stall; the output beat is not consumed while high
- pushout  out  1  output beat valid
- startout  out  1  first output beat of a frame
- endout  out  1  last output beat (final CRC beat)
- dataout  out  DATA_W  output beat
- errout  out  1  one-cycle pulse: frame dropped on overflow

## Operation
- Accept condition: pushin && readyout. Output consume condition: pushout && !stopin.
- States: IDLE, COLLECT, SEND_DATA, SEND_CRC.
- IDLE:
  - readyout=1.
  - An accepted beat without startin is ignored.
  - An accepted beat with startin writes buf[0] and computes crc = step(INIT, datain), count=1.
  - Next state is SEND_DATA if endin is also set, else COLLECT.
- COLLECT:
  - readyout=1.
  - Each accepted beat writes buf[count], updates crc and increments count. endin moves to SEND_DATA.
  - An accepted beat with startin aborts the current frame and restarts collection at that beat (count=1, crc from INIT). No errout.
  - A beat accepted when count==DEPTH raises errout, discards the frame and returns to IDLE. The overflowing beat is dropped.
- SEND_DATA:
  - readyout=0.
  - Emits buf[0..count-1]; startout is high on beat 0 only.
  - After the last payload beat is consumed, the state moves to SEND_CRC.
- SEND_CRC:
  - readyout=0.
  - Emits (crc ^ XOROUT) as CRC_W/DATA_W beats, most-significant beat first. endout is high on the last beat.
  - When the last beat is consumed, the state returns to IDLE.
- CRC step: non-reflected and MSB-first. For each bit of datain from MSB to LSB: fb = crc[CRC_W-1] ^ bit; crc = (crc<<1) ^ (fb ? POLY : 0). Width is truncated to CRC_W.
- The frame counter is log2(DEPTH)+1 bits wide.

## Timing
- Reset values: readyout=0 while reset is asserted and 1 after it is released. pushout=0, startout=0, endout=0, dataout=0, errout=0. State is IDLE, count=0, crc=INIT.
- Outputs are registered.
- The first output beat (pushout=1, startout=1) appears on the cycle after the endin beat is accepted.
- The block sends one beat per cycle while stopin=0. While stopin=1, pushout, startout, endout and dataout hold their values.
- readyout goes high the cycle after the final CRC beat is consumed. That cycle, pushout=0.
- errout asserts the cycle after the overflowing beat and lasts exactly one cycle.
- Reset asserted mid-frame clears everything immediately. The partial frame is lost and nothing further is emitted.
- A frame of exactly DEPTH beats is legal. A single-beat frame (startin and endin on the same beat) is legal.

## Configuration
- CRC_ENC_FRAMECNT_EN defined:
  - Adds output ports frames_out (16 bits) and drops_out (16 bits).
  - frames_out increments when endout is consumed. drops_out increments on each errout.
  - Both counters reset to 0 and wrap at 16'hFFFF→0.
- CRC_ENC_FRAMECNT_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Check value: send bytes 0x31..0x39 with startin on 0x31 and endin on 0x39 (defaults). The output must be 0x31..0x39 then 0x03, 0x76, 0xE6, 0xE7, with startout on 0x31 and endout on 0xE7. Total 13 beats on consecutive cycles.
- Back-pressure: same frame with stopin toggled 1/0 each cycle. dataout must hold while stopin=1, no beat may be duplicated or lost, and readyout must stay 0 until 0xE7 is consumed.
- Overflow: send 17 beats with no endin (DEPTH=16). errout pulses once, one cycle after beat 17. No pushout occurs, and readyout=1 afterwards.
- Abort: send 0xAA, 0xBB, then startin on 0x31 followed by 0x32..0x39 with endin. The output must be identical to the check-value frame and errout must stay 0.
- Single beat plus reset: send 0x00 with startin and endin. The output must be 0x00 followed by the 4 CRC bytes of the one-byte frame, cross-checked against the bench model. Assert reset mid-SEND_CRC: pushout must drop to 0 immediately and readyout must be 1 after release.
- Counters (with CRC_ENC_FRAMECNT_EN defined): send 2 good frames and 1 overflow frame. frames_out must read 2 and drops_out must read 1.
